// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: ISA opcodes, ALU op encodings, sequencer states, NZP codes.
package lc3_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned IMM5_W  = 5;
    localparam int unsigned NZP_W   = 3;

    localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPC_W-1:0] OP_AND = 4'b0101;
    localparam logic [OPC_W-1:0] OP_NOT = 4'b1001;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_NOT  = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_PASS = 2'b11;

    localparam logic [NZP_W-1:0] NZP_N = 3'b100;
    localparam logic [NZP_W-1:0] NZP_Z = 3'b010;
    localparam logic [NZP_W-1:0] NZP_P = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] opcode;
        logic               sr2mux;
        logic [IMM5_W-1:0]  imm5;
    } alu_ctrl_t;

    // NOT is only legal with the all-ones tail in IR[5:0].
    function automatic logic is_legal(input logic [INSTR_W-1:0] ir);
        logic ok;
        ok = 1'b0;
        case (ir[15:12])
            OP_ADD, OP_AND: ok = 1'b1;
            OP_NOT:         ok = (ir[5:0] == 6'h3F);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [NZP_W-1:0] nzp_of(input logic neg, input logic zero);
        logic [NZP_W-1:0] code;
        if (neg)       code = NZP_N;
        else if (zero) code = NZP_Z;
        else           code = NZP_P;
        return code;
    endfunction

endpackage

// File: rtl/lc3_regfile.sv
// LC-3 general register file: two combinational read ports, one synchronous write port, async clear.
// Optional third read port for debug when LC3_OPSEQ_DBG_EN is defined.
module lc3_regfile #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned W     = 16,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [W-1:0]  o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [W-1:0]  o_rdata_b
`ifdef LC3_OPSEQ_DBG_EN
    ,
    input  logic [AW-1:0] i_raddr_d,
    output logic [W-1:0]  o_rdata_d
`endif
);

    logic [W-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

`ifdef LC3_OPSEQ_DBG_EN
    assign o_rdata_d = r_mem[i_raddr_d];
`endif

endmodule

// File: rtl/lc3_op_sequencer.sv
// Multi-cycle decode/execute sequencer for LC-3 ADD/AND/NOT; owns the register file and NZP.
// Optional debug read port enabled by defining LC3_OPSEQ_DBG_EN.
module lc3_op_sequencer
    import lc3_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instr,
    output logic [ALUOP_W-1:0]   alu_opcode,
    output logic                 alu_sr2mux,
    output logic [IMM5_W-1:0]    alu_imm5,
    output logic [W-1:0]         alu_sr1,
    output logic [W-1:0]         alu_sr2,
    input  logic [W-1:0]         alu_result,
    output logic                 done,
    output logic                 illegal,
    output logic [NZP_W-1:0]     nzp
`ifdef LC3_OPSEQ_DBG_EN
    ,
    input  logic [2:0]           dbg_addr,
    output logic [W-1:0]         dbg_data
`endif
);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] w_ir_nxt;
    logic               r_ready;
    logic               w_ready_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_illegal;
    logic               w_illegal_nxt;
    logic [NZP_W-1:0]   r_nzp;
    logic [NZP_W-1:0]   w_nzp_nxt;
    logic [W-1:0]       r_result;
    logic [W-1:0]       w_result_nxt;
    alu_ctrl_t          r_alu;
    alu_ctrl_t          w_alu_nxt;
    logic [W-1:0]       r_sr1;
    logic [W-1:0]       w_sr1_nxt;
    logic [W-1:0]       r_sr2;
    logic [W-1:0]       w_sr2_nxt;
    logic [W-1:0]       w_rd_a;
    logic [W-1:0]       w_rd_b;
    logic               w_we;

    lc3_regfile #(
        .NREGS (NREGS),
        .W     (W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_waddr   (r_ir[11:9]),
        .i_wdata   (r_result),
        .i_raddr_a (r_ir[8:6]),
        .o_rdata_a (w_rd_a),
        .i_raddr_b (r_ir[2:0]),
        .o_rdata_b (w_rd_b)
`ifdef LC3_OPSEQ_DBG_EN
        ,
        .i_raddr_d (dbg_addr),
        .o_rdata_d (dbg_data)
`endif
    );

    assign w_we = (r_state == ST_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state plus next values of every registered output and datapath register.
    always_comb begin
        w_state_nxt   = r_state;
        w_ir_nxt      = r_ir;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        w_nzp_nxt     = r_nzp;
        w_result_nxt  = r_result;
        w_alu_nxt     = r_alu;
        w_sr1_nxt     = r_sr1;
        w_sr2_nxt     = r_sr2;

        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_ir_nxt      = instr;
                    w_illegal_nxt = !is_legal(instr);
                    w_state_nxt   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!is_legal(r_ir)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_EXEC;
                    if (r_ir[15:12] == OP_NOT) begin
                        // ALU inverts its mux output, so the source rides the register path.
                        w_alu_nxt.opcode = ALU_NOT;
                        w_alu_nxt.sr2mux = 1'b0;
                        w_alu_nxt.imm5   = '0;
                        w_sr2_nxt        = w_rd_a;
                    end else begin
                        w_alu_nxt.opcode = (r_ir[15:12] == OP_AND) ? ALU_AND : ALU_ADD;
                        w_alu_nxt.sr2mux = r_ir[5];
                        w_alu_nxt.imm5   = r_ir[4:0];
                        w_sr1_nxt        = w_rd_a;
                        w_sr2_nxt        = w_rd_b;
                    end
                end
            end
            ST_EXEC: begin
                w_result_nxt = alu_result;
                w_done_nxt   = 1'b1;
                w_state_nxt  = ST_WB;
            end
            ST_WB: begin
                w_nzp_nxt   = nzp_of(r_result[W-1], r_result == '0);
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir      <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_nzp     <= NZP_Z;
            r_result  <= '0;
            r_alu     <= '0;
            r_sr1     <= '0;
            r_sr2     <= '0;
        end else begin
            r_ir      <= w_ir_nxt;
            r_ready   <= w_ready_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
            r_nzp     <= w_nzp_nxt;
            r_result  <= w_result_nxt;
            r_alu     <= w_alu_nxt;
            r_sr1     <= w_sr1_nxt;
            r_sr2     <= w_sr2_nxt;
        end
    end

    assign instr_ready = r_ready;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign nzp         = r_nzp;
    assign alu_opcode  = r_alu.opcode;
    assign alu_sr2mux  = r_alu.sr2mux;
    assign alu_imm5    = r_alu.imm5;
    assign alu_sr1     = r_sr1;
    assign alu_sr2     = r_sr2;

endmodule

// File: tb/tb_lc3_op_sequencer.sv
// Directed bench for lc3_op_sequencer with a small LC-3 ALU model closing the result loop.
module tb_lc3_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [1:0]  alu_opcode;
    logic        alu_sr2mux;
    logic [4:0]  alu_imm5;
    logic [15:0] alu_sr1;
    logic [15:0] alu_sr2;
    logic [15:0] alu_result;
    logic        done;
    logic        illegal;
    logic [2:0]  nzp;
`ifdef LC3_OPSEQ_DBG_EN
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
`endif

    int n_total;
    int n_bad;

    lc3_op_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_sr2mux  (alu_sr2mux),
        .alu_imm5    (alu_imm5),
        .alu_sr1     (alu_sr1),
        .alu_sr2     (alu_sr2),
        .alu_result  (alu_result),
        .done        (done),
        .illegal     (illegal),
        .nzp         (nzp)
`ifdef LC3_OPSEQ_DBG_EN
        ,
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`endif
    );

    // Reference ALU: operand2 = alu_sr1, operand0 = alu_sr2.
    logic [15:0] alu_mux;
    assign alu_mux = alu_sr2mux ? {{11{alu_imm5[4]}}, alu_imm5} : alu_sr2;
    always_comb begin
        case (alu_opcode)
            2'b00:   alu_result = alu_sr1 + alu_mux;
            2'b01:   alu_result = alu_sr1 & alu_mux;
            2'b10:   alu_result = ~alu_mux;
            default: alu_result = alu_sr1;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, presents one instruction, returns #1 into the DECODE cycle.
    task automatic send(input logic [15:0] ins);
        int waited;
        waited = 0;
        while (!instr_ready && waited < 20) begin
            tick();
            waited++;
        end
        n_total++;
        if (!instr_ready) begin
            n_bad++;
            $display("FAIL ready_timeout got=%b exp=1", instr_ready);
        end
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = ins;
        tick();
        instr_valid = 1'b0;
        instr       = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instr       = 16'h1225;
        tick();
        tick();
        n_total++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
        n_total++; if (nzp !== 3'b010) begin n_bad++; $display("FAIL rst_nzp got=%b exp=010", nzp); end
        n_total++; if (done !== 1'b0 || illegal !== 1'b0) begin n_bad++; $display("FAIL rst_pulses got=%b%b exp=00", done, illegal); end
        n_total++;
        if ({alu_opcode, alu_sr2mux, alu_imm5, alu_sr1, alu_sr2} !== 40'h0) begin
            n_bad++;
            $display("FAIL rst_alu got=%h exp=0", {alu_opcode, alu_sr2mux, alu_imm5, alu_sr1, alu_sr2});
        end
        instr_valid = 1'b0;
        instr       = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_total++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got=%b exp=1", instr_ready); end
`ifdef LC3_OPSEQ_DBG_EN
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            n_total++; if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL rst_reg%0d got=%h exp=0000", r, dbg_data); end
        end
`endif
    endtask

    task automatic test_add_imm();
        send(16'h1225);
        n_total++; if (instr_ready !== 1'b0 || illegal !== 1'b0) begin n_bad++; $display("FAIL addi_decode got=%b%b exp=00", instr_ready, illegal); end
        tick();
        n_total++; if (alu_sr2mux !== 1'b1 || alu_imm5 !== 5'b00101) begin n_bad++; $display("FAIL addi_exec_mux got=%b/%b exp=1/00101", alu_sr2mux, alu_imm5); end
        n_total++; if (alu_opcode !== 2'b00 || alu_sr1 !== 16'h0000) begin n_bad++; $display("FAIL addi_exec_op got=%b/%h exp=00/0000", alu_opcode, alu_sr1); end
        n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL addi_early_done got=%b exp=0", done); end
        tick();
        n_total++; if (done !== 1'b1) begin n_bad++; $display("FAIL addi_done got=%b exp=1", done); end
        tick();
        n_total++; if (nzp !== 3'b001 || done !== 1'b0 || instr_ready !== 1'b1) begin n_bad++; $display("FAIL addi_wb got=%b/%b/%b exp=001/0/1", nzp, done, instr_ready); end
`ifdef LC3_OPSEQ_DBG_EN
        dbg_addr = 3'd1; #1;
        n_total++; if (dbg_data !== 16'h0005) begin n_bad++; $display("FAIL addi_r1 got=%h exp=0005", dbg_data); end
`endif
    endtask

    task automatic test_add_neg_imm();
        send(16'h147A);
        tick();
        n_total++; if (alu_sr1 !== 16'h0005 || alu_imm5 !== 5'b11010) begin n_bad++; $display("FAIL addn_exec got=%h/%b exp=0005/11010", alu_sr1, alu_imm5); end
        tick();
        tick();
        n_total++; if (nzp !== 3'b100) begin n_bad++; $display("FAIL addn_nzp got=%b exp=100", nzp); end
    endtask

    task automatic test_and_reg();
        send(16'h5681);
        tick();
        n_total++; if (alu_sr2mux !== 1'b0 || alu_opcode !== 2'b01) begin n_bad++; $display("FAIL and_ctrl got=%b/%b exp=0/01", alu_sr2mux, alu_opcode); end
        n_total++; if (alu_sr1 !== 16'hFFFF || alu_sr2 !== 16'h0005) begin n_bad++; $display("FAIL and_ops got=%h/%h exp=ffff/0005", alu_sr1, alu_sr2); end
        tick();
        tick();
        n_total++; if (nzp !== 3'b001) begin n_bad++; $display("FAIL and_nzp got=%b exp=001", nzp); end
    endtask

    task automatic test_not();
        send(16'h98BF);
        tick();
        n_total++; if (alu_opcode !== 2'b10 || alu_sr2mux !== 1'b0 || alu_imm5 !== 5'b0) begin n_bad++; $display("FAIL not_ctrl got=%b/%b/%b exp=10/0/00000", alu_opcode, alu_sr2mux, alu_imm5); end
        n_total++; if (alu_sr2 !== 16'hFFFF) begin n_bad++; $display("FAIL not_sr2 got=%h exp=ffff", alu_sr2); end
        tick();
        tick();
        n_total++; if (nzp !== 3'b010) begin n_bad++; $display("FAIL not_nzp got=%b exp=010", nzp); end
        // R4 readback through a follow-on ADD R5,R4,#0.
        send(16'h1B20);
        tick();
        n_total++; if (alu_sr1 !== 16'h0000) begin n_bad++; $display("FAIL not_r4 got=%h exp=0000", alu_sr1); end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        // ADD R1,R1,R1: operands captured before write-back, R1 5 -> 10.
        send(16'h1241);
        tick();
        n_total++; if (alu_sr1 !== 16'h0005 || alu_sr2 !== 16'h0005) begin n_bad++; $display("FAIL b2b_ops got=%h/%h exp=0005/0005", alu_sr1, alu_sr2); end
        tick();
        tick();
        n_total++; if (nzp !== 3'b001) begin n_bad++; $display("FAIL b2b_nzp got=%b exp=001", nzp); end
        send(16'h1C60);
        tick();
        n_total++; if (alu_sr1 !== 16'h000A) begin n_bad++; $display("FAIL b2b_r1 got=%h exp=000a", alu_sr1); end
        tick();
        tick();
    endtask

    task automatic test_illegal();
        send(16'h0000);
        n_total++; if (illegal !== 1'b1 || instr_ready !== 1'b0) begin n_bad++; $display("FAIL ill0_decode got=%b/%b exp=1/0", illegal, instr_ready); end
        tick();
        n_total++; if (illegal !== 1'b0 || instr_ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ill0_after got=%b/%b/%b exp=0/1/0", illegal, instr_ready, done); end
        n_total++; if (nzp !== 3'b001 || alu_sr1 !== 16'h000A) begin n_bad++; $display("FAIL ill0_hold got=%b/%h exp=001/000a", nzp, alu_sr1); end
        send(16'h9880);
        n_total++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL ill_not_decode got=%b exp=1", illegal); end
        tick();
        n_total++; if (illegal !== 1'b0 || alu_opcode !== 2'b00 || nzp !== 3'b001) begin n_bad++; $display("FAIL ill_not_after got=%b/%b/%b exp=0/00/001", illegal, alu_opcode, nzp); end
    endtask

    task automatic test_reset_abort();
        send(16'h1225);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        n_total++; if (instr_ready !== 1'b1 || nzp !== 3'b010 || done !== 1'b0) begin n_bad++; $display("FAIL abort_state got=%b/%b/%b exp=1/010/0", instr_ready, nzp, done); end
        n_total++; if (alu_sr2mux !== 1'b0 || alu_imm5 !== 5'b0) begin n_bad++; $display("FAIL abort_alu got=%b/%b exp=0/00000", alu_sr2mux, alu_imm5); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_total++; if (done !== 1'b0 || nzp !== 3'b010) begin n_bad++; $display("FAIL abort_nowb got=%b/%b exp=0/010", done, nzp); end
        // ADD R7,R1,#0 exposes R1.
        send(16'h1E60);
        tick();
        n_total++; if (alu_sr1 !== 16'h0000) begin n_bad++; $display("FAIL abort_r1 got=%h exp=0000", alu_sr1); end
        tick();
        tick();
        n_total++; if (nzp !== 3'b010) begin n_bad++; $display("FAIL abort_nzp got=%b exp=010", nzp); end
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
`ifdef LC3_OPSEQ_DBG_EN
        dbg_addr    = 3'd0;
`endif
        test_reset();
        test_add_imm();
        test_add_neg_imm();
        test_and_reg();
        test_not();
        test_back_to_back();
        test_illegal();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3_op_sequencer.md
# lc3_op_sequencer

Multi-cycle decode/execute sequencer for LC-3 operate instructions (ADD, AND, NOT). It sits directly upstream of the LC-3 ALU and drives the ALU's opcode, SR2-mux select, imm5 and both register operands. It owns the 8×16 general register file and the NZP condition codes, and it consumes the ALU result for write-back. Instructions arrive through a valid/ready handshake from the fetch side.

## Interface
Parameters:
- `NREGS`, default 8: number of general registers. Fixed by the ISA; only 8 is supported.
- `W`, default 16: datapath width.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `instr_valid`, in, 1: `instr` is valid.
- `instr_ready`, out, 1: sequencer can accept an instruction. Equals (state == IDLE).
- `instr`, in, 16: LC-3 instruction word.
- `alu_opcode`, out, 2: ALU operation. 00 = ADD, 01 = AND, 10 = NOT.
- `alu_sr2mux`, out, 1: 0 selects the register operand, 1 selects the sign-extended imm5.
- `alu_imm5`, out, 5: `instr[4:0]`.
- `alu_sr1`, out, 16: first operand, driven to the ALU `operand2` port.
- `alu_sr2`, out, 16: register-path operand, driven to the ALU `operand0` port.
- `alu_result`, in, 16: ALU output. Combinational from the ALU.
- `done`, out, 1: one-cycle pulse in the write-back cycle.
- `illegal`, out, 1: one-cycle pulse for an unsupported or malformed instruction.
- `nzp`, out, 3: condition codes {N, Z, P}.

## Operation
States: IDLE → DECODE → EXEC → WB → IDLE.

**IDLE**
- The instruction is latched into IR when `instr_valid && instr_ready`. The next state is DECODE.

**DECODE**
- Decode IR[15:12]:
  - 0001 → ADD
  - 0101 → AND
  - 1001 → NOT, with IR[5:0] required to equal 111111
- Anything else, including NOT with IR[5:0] ≠ 111111:
  - Assert `illegal` for this cycle.
  - Return to IDLE with no register or NZP change.
- Read the register file combinationally and register the operands:
  - ADD/AND: `alu_sr1` ← R[IR[8:6]], `alu_sr2` ← R[IR[2:0]], `alu_sr2mux` ← IR[5], `alu_imm5` ← IR[4:0].
  - NOT: `alu_sr2` ← R[IR[8:6]], `alu_sr2mux` ← 0, `alu_imm5` ← 0. The ALU inverts its mux output, so the source register goes on the register-path port.
  - `alu_opcode` is set per the mapping above.

**EXEC**
- ALU outputs are stable.
- `alu_result` is captured into the result register at the end of the cycle.

**WB**
- `done` = 1.
- At the end of the cycle:
  - R[IR[11:9]] ← result.
  - `nzp` ← 100 if result[15] = 1; 010 if result == 0; 001 otherwise. Exactly one bit is ever set.

**Arithmetic and register rules**
- Arithmetic is 16-bit modulo 2^16 and belongs to the ALU. The sequencer does no arithmetic.
- DR may equal SR1 or SR2. Operands are captured in DECODE, before WB writes.
- ALU-side outputs hold their last values outside DECODE/EXEC.

## Timing
- Accept edge = E0.
- DECODE occupies the cycle after E0, EXEC the next, and WB the one after that.
- `done` is high during WB. The register and `nzp` update on the edge that ends WB.
- Throughput: one instruction per 4 cycles. `instr_ready` is low from DECODE through WB.
- An illegal instruction costs 2 cycles: accept, then DECODE with `illegal` high.
- Reset values:
  - state = IDLE, so `instr_ready` = 1 during reset. Handshakes are ignored while `rst_n` = 0.
  - R0–R7 = 0.
  - `nzp` = 010.
  - `done` = 0, `illegal` = 0.
  - `alu_*` outputs = 0.
- Reset asserted mid-operation, in any state: the instruction is abandoned, no write-back occurs, and everything returns to the reset values.
- `instr_valid` with `instr_ready` low is not an accept. The source must hold `instr_valid` and `instr` until ready.

## Configuration
- `LC3_OPSEQ_DBG_EN`
  - Defined: adds input `dbg_addr` (3 bits) and output `dbg_data` (16 bits). `dbg_data` = R[`dbg_addr`] combinationally; it reflects a write on the cycle after WB.
  - Undefined: the ports and logic are absent.
  - Functional behaviour is otherwise identical either way.

## Structure
- Shared package `lc3_pkg` holds:
  - ISA opcode constants (OP_ADD = 4'b0001, OP_AND = 4'b0101, OP_NOT = 4'b1001).
  - ALU op constants (ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS).
  - The sequencer state typedef.
  - The NZP encodings.
- Sub-module `lc3_regfile`: 8×16, two combinational read ports, one synchronous write port with write enable, asynchronous active-low clear. It is reused by later datapath stages.

## Test plan
- **Reset:** hold `rst_n` low, release → `instr_ready` = 1, `nzp` = 010, all registers 0 (via the debug port when `LC3_OPSEQ_DBG_EN` is defined).
- **ADD immediate:** accept 0x1225 (ADD R1,R0,#5) → `alu_sr2mux` = 1 and `alu_imm5` = 00101 in EXEC; `done` 3 cycles after accept; R1 = 0x0005, `nzp` = 001.
- **ADD negative immediate:** then 0x147A (ADD R2,R1,#-6) → R2 = 0xFFFF, `nzp` = 100.
- **AND register mode:** then 0x5681 (AND R3,R2,R1) → `alu_sr2mux` = 0, `alu_sr1` = 0xFFFF, `alu_sr2` = 0x0005; R3 = 0x0005, `nzp` = 001.
- **NOT:** then 0x98BF (NOT R4,R2) → `alu_opcode` = 10, `alu_sr2` = 0xFFFF, `alu_sr2mux` = 0; R4 = 0x0000, `nzp` = 010.
- **Illegal and reset abort:**
  - 0x0000 → `illegal` pulse in DECODE, no register/`nzp` change, `instr_ready` back the next cycle.
  - 0x9880 (NOT with bad IR[5:0]) → `illegal`.
  - Reset asserted during EXEC of 0x1225 → R1 stays 0, `nzp` = 010.
